// File: rtl/param_stack_if.sv
// param_stack_if: bus bundle between a stack user and param_stack
//   din/push/pop/clr_err : requests from the user (master) into the stack (slave)
//   dout/count/empty/full/overflow/underflow : stack state back to the user
interface param_stack_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] din;
   logic             push;
   logic             pop;
   logic             clr_err;
   logic [WIDTH-1:0] dout;
   logic [AW:0]      count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;
   modport master (
      output din, push, pop, clr_err,
      input  dout, count, empty, full, overflow, underflow
   );
   modport slave (
      input  din, push, pop, clr_err,
      output dout, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with replace-top, registered top output and sticky error flags
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : param_stack_if slave (din, push, pop, clr_err in; dout, count, empty, full, overflow, underflow out)
module param_stack #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 8,
   parameter int EDGE_DETECT = 1
) (
   input logic          clk,
   input logic          rst,
   param_stack_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] ADR_ONE  = AW'(1);
   localparam logic [AW-1:0] ADR_TWO  = AW'(2);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             wr;
   logic [AW-1:0]    wa, ra;
   logic             p, q, emp, ful;

   if (EDGE_DETECT != 0) begin : g_edge
      // per input: [0]=s1, [1]=s2 (synchronised), [2]=s3 (delayed s2)
      logic [2:0] ps_q, qs_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ps_q <= '0;
            qs_q <= '0;
         end else begin
            ps_q <= {ps_q[1:0], bus.push};
            qs_q <= {qs_q[1:0], bus.pop};
         end
      end
      assign p = ps_q[1] & ~ps_q[2];
      assign q = qs_q[1] & ~qs_q[2];
   end else begin : g_strobe
      assign p = bus.push;
      assign q = bus.pop;
   end

   assign emp = cnt_q == '0;
   assign ful = cnt_q == CNT_FULL;
   // low address bits wrap modulo DEPTH, so count==DEPTH still addresses the right entries
   assign ra  = cnt_q[AW-1:0] - ADR_TWO;

   always_comb begin
      cnt_d  = cnt_q;
      dout_d = dout_q;
      ovf_d  = ovf_q & ~bus.clr_err;
      unf_d  = unf_q & ~bus.clr_err;
      wr     = 1'b0;
      wa     = cnt_q[AW-1:0];
      if (p && q) begin
         wr     = 1'b1;
         dout_d = bus.din;
         if (emp) cnt_d = cnt_q + CNT_ONE;
         else     wa    = cnt_q[AW-1:0] - ADR_ONE;
      end else if (p) begin
         if (ful) begin
            ovf_d = 1'b1;
         end else begin
            wr     = 1'b1;
            cnt_d  = cnt_q + CNT_ONE;
            dout_d = bus.din;
         end
      end else if (q) begin
         if (emp) begin
            unf_d = 1'b1;
         end else begin
            cnt_d  = cnt_q - CNT_ONE;
            dout_d = (cnt_q == CNT_ONE) ? '0 : mem_q[ra];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         dout_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   // storage is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (wr) mem_q[wa] <= bus.din;
   end

   assign bus.dout      = dout_q;
   assign bus.count     = cnt_q;
   assign bus.empty     = emp;
   assign bus.full      = ful;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed scoreboard bench for param_stack in strobe and edge-detect modes
module tb_param_stack;
   typedef struct {
      string      tag;
      bit         sel_e;
      logic [3:0] cnt;
      logic [7:0] dout;
      logic       ovf;
      logic       unf;
   } exp_t;

   logic clk, rst;
   int   tests = 0;
   int   fails = 0;
   exp_t sbq[$];

   param_stack_if #(.WIDTH(8), .DEPTH(8)) sb ();
   param_stack_if #(.WIDTH(8), .DEPTH(8)) eb ();

   param_stack #(.WIDTH(8), .DEPTH(8), .EDGE_DETECT(0)) dut_s (.clk(clk), .rst(rst), .bus(sb));
   param_stack #(.WIDTH(8), .DEPTH(8), .EDGE_DETECT(1)) dut_e (.clk(clk), .rst(rst), .bus(eb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic sb_push(input string tag, input bit sel_e, input logic [3:0] c,
                          input logic [7:0] d, input logic o, input logic u);
      exp_t e;
      e.tag   = tag;
      e.sel_e = sel_e;
      e.cnt   = c;
      e.dout  = d;
      e.ovf   = o;
      e.unf   = u;
      sbq.push_back(e);
   endtask

   task automatic check_next();
      exp_t       e;
      logic [3:0] c, fx, fo;
      logic [7:0] d;
      if (sbq.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_underrun obs=empty exp=entry");
         return;
      end
      e  = sbq.pop_front();
      c  = e.sel_e ? eb.count : sb.count;
      d  = e.sel_e ? eb.dout : sb.dout;
      fo = e.sel_e ? {eb.empty, eb.full, eb.overflow, eb.underflow}
                   : {sb.empty, sb.full, sb.overflow, sb.underflow};
      fx = {e.cnt == 4'd0, e.cnt == 4'd8, e.ovf, e.unf};
      tests++;
      assert (c === e.cnt) else begin
         fails++;
         $error("FAIL %s count obs=%0d exp=%0d", e.tag, c, e.cnt);
      end
      tests++;
      assert (d === e.dout) else begin
         fails++;
         $error("FAIL %s dout obs=%h exp=%h", e.tag, d, e.dout);
      end
      tests++;
      assert (fo === fx) else begin
         fails++;
         $error("FAIL %s flags(empty,full,ovf,unf) obs=%b exp=%b", e.tag, fo, fx);
      end
   endtask

   task automatic op(input string tag, input logic ps, input logic pp, input logic cl,
                     input logic [7:0] din, input logic [3:0] c, input logic [7:0] dx,
                     input logic o, input logic u);
      @(negedge clk);
      sb.push    = ps;
      sb.pop     = pp;
      sb.clr_err = cl;
      sb.din     = din;
      sb_push(tag, 1'b0, c, dx, o, u);
      @(posedge clk);
      #1;
      check_next();
   endtask

   task automatic tick_e(input string tag, input logic [3:0] c, input logic [7:0] dx);
      sb_push(tag, 1'b1, c, dx, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_next();
   endtask

   initial begin
      rst = 1'b1;
      {sb.push, sb.pop, sb.clr_err, sb.din} = '0;
      {eb.push, eb.pop, eb.clr_err, eb.din} = '0;
      repeat (2) @(posedge clk);
      #1;
      sb_push("reset_s", 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
      check_next();
      sb_push("reset_e", 1'b1, 4'd0, 8'h00, 1'b0, 1'b0);
      check_next();
      @(negedge clk);
      rst = 1'b0;

      for (int i = 1; i <= 8; i++)
         op("fill", 1, 0, 0, 8'(17 * i), 4'(i), 8'(17 * i), 0, 0);
      op("overflow", 1, 0, 0, 8'h99, 4'd8, 8'h88, 1, 0);
      for (int i = 1; i <= 8; i++)
         op("drain", 0, 1, 0, 8'h00, 4'(8 - i), 8'(17 * (8 - i)), 1, 0);
      op("underflow", 0, 1, 0, 8'h00, 4'd0, 8'h00, 1, 1);
      op("clr_both", 0, 0, 1, 8'h00, 4'd0, 8'h00, 0, 0);

      op("rp_push1", 1, 0, 0, 8'h11, 4'd1, 8'h11, 0, 0);
      op("rp_push2", 1, 0, 0, 8'h22, 4'd2, 8'h22, 0, 0);
      op("rp_push3", 1, 0, 0, 8'h33, 4'd3, 8'h33, 0, 0);
      op("replace", 1, 1, 0, 8'hAB, 4'd3, 8'hAB, 0, 0);
      op("rp_pop1", 0, 1, 0, 8'h00, 4'd2, 8'h22, 0, 0);
      op("rp_pop2", 0, 1, 0, 8'h00, 4'd1, 8'h11, 0, 0);
      op("rp_pop3", 0, 1, 0, 8'h00, 4'd0, 8'h00, 0, 0);

      op("pp_empty", 1, 1, 0, 8'h5A, 4'd1, 8'h5A, 0, 0);
      op("pp_pop", 0, 1, 0, 8'h00, 4'd0, 8'h00, 0, 0);

      for (int i = 1; i <= 8; i++)
         op("refill", 1, 0, 0, 8'(17 * i), 4'(i), 8'(17 * i), 0, 0);
      op("ovf_again", 1, 0, 0, 8'h99, 4'd8, 8'h88, 1, 0);
      op("clr_vs_set", 1, 0, 1, 8'h77, 4'd8, 8'h88, 1, 0);
      op("clr_alone", 0, 0, 1, 8'h00, 4'd8, 8'h88, 0, 0);
      op("rf_pop1", 0, 1, 0, 8'h00, 4'd7, 8'h77, 0, 0);
      op("rf_pop2", 0, 1, 0, 8'h00, 4'd6, 8'h66, 0, 0);
      op("rf_pop3", 0, 1, 0, 8'h00, 4'd5, 8'h55, 0, 0);

      #2;
      rst = 1'b1;
      #1;
      sb_push("async_rst", 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
      check_next();
      rst = 1'b0;
      op("post_rst", 1, 0, 0, 8'h01, 4'd1, 8'h01, 0, 0);
      op("idle", 0, 0, 0, 8'h00, 4'd1, 8'h01, 0, 0);

      @(negedge clk);
      eb.push = 1'b1;
      eb.din  = 8'h3C;
      tick_e("edge_k", 4'd0, 8'h00);
      tick_e("edge_k1", 4'd0, 8'h00);
      tick_e("edge_k2", 4'd1, 8'h3C);
      for (int i = 0; i < 7; i++) tick_e("edge_hold", 4'd1, 8'h3C);
      @(negedge clk);
      eb.push = 1'b0;
      for (int i = 0; i < 3; i++) tick_e("edge_release", 4'd1, 8'h3C);

      tests++;
      assert (sbq.size() == 0) else begin
         fails++;
         $error("FAIL scoreboard_leftover obs=%0d exp=0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
